// File: rtl/ppu_pkg.sv
// PPU register file shared definitions.
// Register indices, loopy field positions and scroll helpers.
package ppu_pkg;

  localparam int V_W = 15;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;

  localparam int CX_LO = 0;
  localparam int CX_HI = 4;
  localparam int CY_LO = 5;
  localparam int CY_HI = 9;
  localparam int NT_X  = 10;
  localparam int NT_Y  = 11;
  localparam int FY_LO = 12;
  localparam int FY_HI = 14;

  function automatic logic [V_W-1:0] loopy_inc_x(
    input logic [V_W-1:0] v
  );
    logic [V_W-1:0] r;
    r = v;
    if (v[CX_HI:CX_LO] == 5'd31) begin
      r[CX_HI:CX_LO] = 5'd0;
      r[NT_X]        = ~v[NT_X];
    end else begin
      r[CX_HI:CX_LO] = v[CX_HI:CX_LO] + 5'd1;
    end
    return r;
  endfunction

  function automatic logic [V_W-1:0] loopy_inc_y(
    input logic [V_W-1:0] v
  );
    logic [V_W-1:0] r;
    r = v;
    if (v[FY_HI:FY_LO] != 3'd7) begin
      r[FY_HI:FY_LO] = v[FY_HI:FY_LO] + 3'd1;
    end else begin
      r[FY_HI:FY_LO] = 3'd0;
      if (v[CY_HI:CY_LO] == 5'd29) begin
        r[CY_HI:CY_LO] = 5'd0;
        r[NT_Y]        = ~v[NT_Y];
      end else if (v[CY_HI:CY_LO] == 5'd31) begin
        r[CY_HI:CY_LO] = 5'd0;
      end else begin
        r[CY_HI:CY_LO] = v[CY_HI:CY_LO] + 5'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ppu_vaddr.sv
// Loopy scroll/address state: v, t, fine x and the write toggle.
// Handles $2000/$2005/$2006 t updates and all v stepping.
module ppu_vaddr
  import ppu_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_wr_ctrl,
  input  logic           i_wr_scroll,
  input  logic           i_wr_addr,
  input  logic           i_data_acc,
  input  logic           i_clr_w,
  input  logic [7:0]     i_wdata,
  input  logic           i_inc32,
  input  logic           i_render_on,
  input  logic           i_inc_x,
  input  logic           i_inc_y,
  input  logic           i_copy_x,
  input  logic           i_copy_y,
  output logic [V_W-1:0] o_v,
  output logic [2:0]     o_fine_x
);

  logic [V_W-1:0] v_q, v_d;
  logic [V_W-1:0] t_q, t_d;
  logic [V_W-1:0] v_r;
  logic [2:0]     x_q, x_d;
  logic           w_q, w_d;

  // Next-state for t, x, w and the prioritised v update.
  always_comb begin
    t_d = t_q;
    x_d = x_q;
    w_d = w_q;
    v_d = v_q;
    v_r = v_q;

    if (i_wr_ctrl) begin
      t_d[NT_Y:NT_X] = i_wdata[1:0];
    end

    if (i_wr_scroll) begin
      if (!w_q) begin
        t_d[CX_HI:CX_LO] = i_wdata[7:3];
        x_d              = i_wdata[2:0];
      end else begin
        t_d[CY_HI:CY_LO] = i_wdata[7:3];
        t_d[FY_HI:FY_LO] = i_wdata[2:0];
      end
      w_d = ~w_q;
    end

    if (i_wr_addr) begin
      if (!w_q) begin
        t_d[13:8] = i_wdata[5:0];
        t_d[14]   = 1'b0;
      end else begin
        t_d[7:0]  = i_wdata;
      end
      w_d = ~w_q;
    end

    if (i_clr_w) begin
      w_d = 1'b0;
    end

    // copy is applied after inc so it wins on shared fields
    if (i_render_on) begin
      if (i_inc_x) v_r = loopy_inc_x(v_r);
      if (i_inc_y) v_r = loopy_inc_y(v_r);
      if (i_copy_x) begin
        v_r[NT_X]        = t_q[NT_X];
        v_r[CX_HI:CX_LO] = t_q[CX_HI:CX_LO];
      end
      if (i_copy_y) begin
        v_r[FY_HI:NT_Y]  = t_q[FY_HI:NT_Y];
        v_r[CY_HI:CY_LO] = t_q[CY_HI:CY_LO];
      end
    end

    if (i_wr_addr && w_q) begin
      v_d = t_d;
    end else if (i_data_acc) begin
      if (i_render_on) begin
        v_d = loopy_inc_y(loopy_inc_x(v_q));
      end else begin
        v_d = v_q + (i_inc32 ? 15'd32 : 15'd1);
      end
    end else begin
      v_d = v_r;
    end
  end

  // Scroll state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v_q <= '0;
      t_q <= '0;
      x_q <= '0;
      w_q <= 1'b0;
    end else begin
      v_q <= v_d;
      t_q <= t_d;
      x_q <= x_d;
      w_q <= w_d;
    end
  end

  assign o_v      = v_q;
  assign o_fine_x = x_q;

endmodule

// File: rtl/ppu_reg_file.sv
// CPU-visible PPU register file ($2000-$2007).
// Bus decode, status/NMI, OAM port, VRAM port and open-bus decay.
module ppu_reg_file
  import ppu_pkg::*;
#(
  parameter int VRAM_AW = 14,
  parameter int OAM_AW  = 8,
  parameter int DECAY_W = 20
) (
  input  logic               i_cpu_clk,
  input  logic               i_cpu_rst,
  input  logic               i_bus_valid,
  input  logic [2:0]         i_bus_addr,
  input  logic               i_bus_wn,
  input  logic [7:0]         i_bus_wdata,
  output logic [7:0]         o_ppu_rdata,
  output logic [OAM_AW-1:0]  o_oam_addr,
  output logic               o_oam_we,
  output logic [7:0]         o_oam_wdata,
  input  logic [7:0]         i_oam_rdata,
  output logic [VRAM_AW-1:0] o_vram_addr,
  output logic               o_vram_we,
  output logic               o_vram_re,
  output logic [7:0]         o_vram_wdata,
  input  logic [7:0]         i_vram_rdata,
  input  logic               i_render_on,
  input  logic               i_inc_x,
  input  logic               i_inc_y,
  input  logic               i_copy_x,
  input  logic               i_copy_y,
  output logic [14:0]        o_v,
  output logic [2:0]         o_fine_x,
  output logic [7:0]         o_ppuctrl,
  output logic [7:0]         o_ppumask,
  input  logic               i_spr_ovfl,
  input  logic               i_spr_0hit,
  input  logic               i_vblank,
  output logic               o_nmi_n
);

  logic acc, wr, rd;
  logic wr_ctrl, wr_mask, wr_oaddr, wr_odata;
  logic wr_scroll, wr_addr, data_acc;
  logic rd_status, rd_data;
  logic vbl_rise, vbl_fall;
  logic pal_hit;

  logic [7:0]         ctrl_q, ctrl_d;
  logic [7:0]         mask_q, mask_d;
  logic [OAM_AW-1:0]  oam_q, oam_d;
  logic [7:0]         buf_q, buf_d;
  logic [7:0]         ob_q, ob_d;
  logic [DECAY_W-1:0] cnt_q, cnt_d;
  logic               vbl_q, vbl_d;
  logic               vb_q;
  logic               nmi_n_q, nmi_n_d;
  logic [7:0]         rdata;
  logic [V_W-1:0]     v;

  assign acc = i_bus_valid & ~i_cpu_rst;
  assign wr  = acc & ~i_bus_wn;
  assign rd  = acc & i_bus_wn;

  assign wr_ctrl   = wr && (i_bus_addr == REG_CTRL);
  assign wr_mask   = wr && (i_bus_addr == REG_MASK);
  assign wr_oaddr  = wr && (i_bus_addr == REG_OAMADDR);
  assign wr_odata  = wr && (i_bus_addr == REG_OAMDATA);
  assign wr_scroll = wr && (i_bus_addr == REG_SCROLL);
  assign wr_addr   = wr && (i_bus_addr == REG_ADDR);
  assign data_acc  = acc && (i_bus_addr == REG_DATA);
  assign rd_status = rd && (i_bus_addr == REG_STATUS);
  assign rd_data   = rd && (i_bus_addr == REG_DATA);

  assign vbl_rise = i_vblank & ~vb_q;
  assign vbl_fall = ~i_vblank & vb_q;
  assign pal_hit  = (v[13:8] == 6'h3F);

  ppu_vaddr u_vaddr (
    .i_clk       (i_cpu_clk),
    .i_rst       (i_cpu_rst),
    .i_wr_ctrl   (wr_ctrl),
    .i_wr_scroll (wr_scroll),
    .i_wr_addr   (wr_addr),
    .i_data_acc  (data_acc),
    .i_clr_w     (rd_status),
    .i_wdata     (i_bus_wdata),
    .i_inc32     (ctrl_q[2]),
    .i_render_on (i_render_on),
    .i_inc_x     (i_inc_x),
    .i_inc_y     (i_inc_y),
    .i_copy_x    (i_copy_x),
    .i_copy_y    (i_copy_y),
    .o_v         (v),
    .o_fine_x    (o_fine_x)
  );

  // Read data mux; silent unless a read is in progress.
  always_comb begin
    rdata = 8'h00;
    if (rd) begin
      case (i_bus_addr)
        REG_STATUS:
          rdata = {vbl_q, i_spr_0hit, i_spr_ovfl, ob_q[4:0]};
        REG_OAMDATA:
          rdata = i_oam_rdata;
        REG_DATA:
          rdata = pal_hit ? {ob_q[7:6], i_vram_rdata[5:0]}
                          : buf_q;
        default:
          rdata = ob_q;
      endcase
    end
  end

  // Next-state for control regs, OAM pointer, buffer, status and decay.
  always_comb begin
    ctrl_d = wr_ctrl ? i_bus_wdata : ctrl_q;
    mask_d = wr_mask ? i_bus_wdata : mask_q;
    buf_d  = rd_data ? i_vram_rdata : buf_q;

    oam_d = oam_q;
    if (wr_oaddr) begin
      oam_d = i_bus_wdata[OAM_AW-1:0];
    end else if (wr_odata) begin
      oam_d = oam_q + 1'b1;
    end

    vbl_d = vbl_q;
    if (rd_status) begin
      vbl_d = 1'b0;
    end else if (vbl_rise) begin
      vbl_d = 1'b1;
    end else if (vbl_fall) begin
      vbl_d = 1'b0;
    end
    nmi_n_d = ~(ctrl_d[7] & vbl_d);

    // open-bus latch fades once the counter saturates
    cnt_d = cnt_q;
    ob_d  = ob_q;
    if (acc) begin
      cnt_d = '0;
      ob_d  = i_bus_wn ? rdata : i_bus_wdata;
    end else if (!(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_d) ob_d = 8'h00;
    end
  end

  // Register-file state.
  always_ff @(posedge i_cpu_clk or posedge i_cpu_rst) begin
    if (i_cpu_rst) begin
      ctrl_q  <= '0;
      mask_q  <= '0;
      oam_q   <= '0;
      buf_q   <= '0;
      ob_q    <= '0;
      cnt_q   <= '0;
      vbl_q   <= 1'b0;
      vb_q    <= 1'b0;
      nmi_n_q <= 1'b1;
    end else begin
      ctrl_q  <= ctrl_d;
      mask_q  <= mask_d;
      oam_q   <= oam_d;
      buf_q   <= buf_d;
      ob_q    <= ob_d;
      cnt_q   <= cnt_d;
      vbl_q   <= vbl_d;
      vb_q    <= i_vblank;
      nmi_n_q <= nmi_n_d;
    end
  end

  generate
    if (VRAM_AW > V_W) begin : g_wide
      assign o_vram_addr = {{(VRAM_AW-V_W){1'b0}}, v};
    end else begin : g_narrow
      assign o_vram_addr = v[VRAM_AW-1:0];
    end
  endgenerate

  assign o_ppu_rdata  = rdata;
  assign o_oam_addr   = oam_q;
  assign o_oam_we     = wr_odata;
  assign o_oam_wdata  = i_bus_wdata;
  assign o_vram_we    = data_acc & ~i_bus_wn;
  assign o_vram_re    = rd_data;
  assign o_vram_wdata = i_bus_wdata;
  assign o_v          = v;
  assign o_ppuctrl    = ctrl_q;
  assign o_ppumask    = mask_q;
  assign o_nmi_n      = nmi_n_q;

endmodule

// File: tb/tb_ppu_reg_file.sv
// Directed bench for ppu_reg_file.
// Hand-computed vectors for scroll, status, OAM, VRAM and decay.
module tb_ppu_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_bus_valid = 1'b0;
  logic [2:0]  i_bus_addr = 3'd0;
  logic        i_bus_wn = 1'b1;
  logic [7:0]  i_bus_wdata = 8'h00;
  logic [7:0]  o_ppu_rdata;
  logic [7:0]  o_oam_addr;
  logic        o_oam_we;
  logic [7:0]  o_oam_wdata;
  logic [7:0]  i_oam_rdata = 8'h00;
  logic [14:0] o_vram_addr;
  logic        o_vram_we;
  logic        o_vram_re;
  logic [7:0]  o_vram_wdata;
  logic [7:0]  i_vram_rdata = 8'h00;
  logic        i_render_on = 1'b0;
  logic        i_inc_x = 1'b0;
  logic        i_inc_y = 1'b0;
  logic        i_copy_x = 1'b0;
  logic        i_copy_y = 1'b0;
  logic [14:0] o_v;
  logic [2:0]  o_fine_x;
  logic [7:0]  o_ppuctrl;
  logic [7:0]  o_ppumask;
  logic        i_spr_ovfl = 1'b0;
  logic        i_spr_0hit = 1'b0;
  logic        i_vblank = 1'b0;
  logic        o_nmi_n;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] r;

  ppu_reg_file #(
    .VRAM_AW (15),
    .OAM_AW  (8),
    .DECAY_W (4)
  ) dut (
    .i_cpu_clk    (clk),
    .i_cpu_rst    (rst),
    .i_bus_valid  (i_bus_valid),
    .i_bus_addr   (i_bus_addr),
    .i_bus_wn     (i_bus_wn),
    .i_bus_wdata  (i_bus_wdata),
    .o_ppu_rdata  (o_ppu_rdata),
    .o_oam_addr   (o_oam_addr),
    .o_oam_we     (o_oam_we),
    .o_oam_wdata  (o_oam_wdata),
    .i_oam_rdata  (i_oam_rdata),
    .o_vram_addr  (o_vram_addr),
    .o_vram_we    (o_vram_we),
    .o_vram_re    (o_vram_re),
    .o_vram_wdata (o_vram_wdata),
    .i_vram_rdata (i_vram_rdata),
    .i_render_on  (i_render_on),
    .i_inc_x      (i_inc_x),
    .i_inc_y      (i_inc_y),
    .i_copy_x     (i_copy_x),
    .i_copy_y     (i_copy_y),
    .o_v          (o_v),
    .o_fine_x     (o_fine_x),
    .o_ppuctrl    (o_ppuctrl),
    .o_ppumask    (o_ppumask),
    .i_spr_ovfl   (i_spr_ovfl),
    .i_spr_0hit   (i_spr_0hit),
    .i_vblank     (i_vblank),
    .o_nmi_n      (o_nmi_n)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk15(input string tag, input logic [14:0] obs,
                       input logic [14:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic setbus(input logic [2:0] a, input logic wn,
                        input logic [7:0] d);
    i_bus_valid = 1'b1;
    i_bus_addr  = a;
    i_bus_wn    = wn;
    i_bus_wdata = d;
    #1;
  endtask

  task automatic idlebus;
    i_bus_valid = 1'b0;
    i_bus_addr  = 3'd0;
    i_bus_wn    = 1'b1;
    i_bus_wdata = 8'h00;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    setbus(a, 1'b0, d);
    tick();
    idlebus();
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] q);
    setbus(a, 1'b1, 8'h00);
    q = o_ppu_rdata;
    tick();
    idlebus();
  endtask

  task automatic rstrobe(input logic ro, input logic ix,
                         input logic iy, input logic cx,
                         input logic cy);
    i_render_on = ro;
    i_inc_x     = ix;
    i_inc_y     = iy;
    i_copy_x    = cx;
    i_copy_y    = cy;
    tick();
    i_render_on = 1'b0;
    i_inc_x     = 1'b0;
    i_inc_y     = 1'b0;
    i_copy_x    = 1'b0;
    i_copy_y    = 1'b0;
  endtask

  initial begin
    // reset state, with bus activity masked
    tick();
    chk1("rst_nmi", o_nmi_n, 1'b1);
    chk15("rst_v", o_v, 15'h0000);
    chk8("rst_ctrl", o_ppuctrl, 8'h00);
    chk8("rst_mask", o_ppumask, 8'h00);
    chk8("rst_finex", {5'd0, o_fine_x}, 8'h00);
    chk8("rst_oamaddr", o_oam_addr, 8'h00);
    setbus(3'd7, 1'b0, 8'h11);
    chk1("rst_vram_we", o_vram_we, 1'b0);
    setbus(3'd4, 1'b0, 8'h11);
    chk1("rst_oam_we", o_oam_we, 1'b0);
    setbus(3'd2, 1'b1, 8'h00);
    chk8("rst_rdata", o_ppu_rdata, 8'h00);
    idlebus();
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk8("idle_rdata", o_ppu_rdata, 8'h00);

    // reset between the two $2006 writes drops the toggle
    wr(3'd6, 8'h12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    wr(3'd6, 8'h34);
    wr(3'd6, 8'h56);
    chk15("rst_mid_pair_v", o_v, 15'h3456);

    // OAM pointer, write strobe and wrap, read without increment
    wr(3'd3, 8'hFF);
    setbus(3'd4, 1'b0, 8'h77);
    chk1("oam_we", o_oam_we, 1'b1);
    chk8("oam_addr_wr", o_oam_addr, 8'hFF);
    chk8("oam_wdata", o_oam_wdata, 8'h77);
    tick();
    idlebus();
    chk8("oam_addr_wrap", o_oam_addr, 8'h00);
    i_oam_rdata = 8'h9C;
    rd(3'd4, r);
    chk8("oam_rd", r, 8'h9C);
    chk8("oam_addr_hold", o_oam_addr, 8'h00);

    wr(3'd1, 8'h1E);
    chk8("mask", o_ppumask, 8'h1E);

    // palette read through $2007
    wr(3'd6, 8'h3F);
    wr(3'd6, 8'h10);
    chk15("pal_v", o_v, 15'h3F10);
    i_vram_rdata = 8'hFF;
    setbus(3'd7, 1'b1, 8'h00);
    chk8("pal_rd", o_ppu_rdata, 8'h3F);
    chk1("pal_re", o_vram_re, 1'b1);
    chk15("pal_addr", o_vram_addr, 15'h3F10);
    tick();
    idlebus();
    chk15("pal_v_inc", o_v, 15'h3F11);

    // buffered reads outside palette space
    wr(3'd6, 8'h20);
    wr(3'd6, 8'h00);
    i_vram_rdata = 8'h44;
    rd(3'd7, r);
    chk8("buf_rd1", r, 8'hFF);
    rd(3'd7, r);
    chk8("buf_rd2", r, 8'h44);
    chk15("buf_v", o_v, 15'h2002);

    // renderer strobes: ignored when off, inc_x wrap, $2007 while on
    wr(3'd6, 8'h00);
    wr(3'd6, 8'h1F);
    rstrobe(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk15("strobe_ignored", o_v, 15'h001F);
    rstrobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk15("inc_x_wrap", o_v, 15'h0400);
    i_render_on = 1'b1;
    rd(3'd7, r);
    i_render_on = 1'b0;
    chk15("data_render_on", o_v, 15'h1401);

    // increment-by-32 across the 15-bit wrap
    wr(3'd0, 8'h07);
    wr(3'd5, 8'h85);
    wr(3'd5, 8'hFF);
    chk8("fine_x", {5'd0, o_fine_x}, 8'h05);
    rstrobe(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk15("copy_v", o_v, 15'h7FF0);
    setbus(3'd7, 1'b0, 8'h5A);
    chk1("inc32_we", o_vram_we, 1'b1);
    chk15("inc32_addr", o_vram_addr, 15'h7FF0);
    chk8("inc32_wdata", o_vram_wdata, 8'h5A);
    tick();
    idlebus();
    chk15("inc32_wrap", o_v, 15'h0010);

    // inc_y at fine 7 / coarse 29
    wr(3'd0, 8'h00);
    wr(3'd5, 8'h00);
    wr(3'd5, 8'hEF);
    rstrobe(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk15("incy_setup", o_v, 15'h73A0);
    rstrobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk15("inc_y_wrap", o_v, 15'h0800);

    // vblank NMI and $2002 clearing flag and toggle
    wr(3'd0, 8'h80);
    wr(3'd6, 8'h21);
    i_vblank   = 1'b1;
    i_spr_0hit = 1'b1;
    tick();
    chk1("nmi_assert", o_nmi_n, 1'b0);
    rd(3'd2, r);
    chk8("status_vbl", r, 8'hC1);
    chk1("nmi_release", o_nmi_n, 1'b1);
    wr(3'd6, 8'h22);
    wr(3'd6, 8'h33);
    chk15("status_clr_w", o_v, 15'h2233);

    // $2002 read on the rising-edge cycle suppresses the flag
    i_vblank = 1'b0;
    tick();
    i_vblank = 1'b1;
    setbus(3'd2, 1'b1, 8'h00);
    chk8("race_rd", o_ppu_rdata, 8'h53);
    tick();
    idlebus();
    chk1("race_nmi1", o_nmi_n, 1'b1);
    tick();
    chk1("race_nmi2", o_nmi_n, 1'b1);
    rd(3'd2, r);
    chk8("race_flag", r, 8'h53);
    i_vblank   = 1'b0;
    i_spr_0hit = 1'b0;

    // open-bus decay with a 4-bit counter
    wr(3'd1, 8'hA5);
    chk8("decay_mask", o_ppumask, 8'hA5);
    repeat (14) tick();
    rd(3'd0, r);
    chk8("decay_14", r, 8'hA5);
    wr(3'd1, 8'hA5);
    repeat (15) tick();
    rd(3'd0, r);
    chk8("decay_15", r, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
